// File: rtl/prbs_checker.sv
// Word-wide PRBS receive checker: self-seeds from the stream, qualifies lock, counts errors.
// Optional per-bit error counting is enabled by defining PRBS_BIT_ERR_COUNT_EN.
module prbs_checker #(
  parameter int NUM_BITS   = 32,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_data_valid,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic                i_clear,
  output logic                o_locked,
  output logic                o_err,
  output logic [31:0]         o_word_count,
  output logic [31:0]         o_word_err_count,
  output logic [31:0]         o_bit_err_count
);

  if (NUM_BITS != 8 && NUM_BITS != 16 && NUM_BITS != 32) begin : g_bad_width
    $error("prbs_checker: NUM_BITS must be 8, 16 or 32");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock
    $error("prbs_checker: LOCK_COUNT must be 1..255");
  end
  if (LOSS_COUNT < 1 || LOSS_COUNT > 255) begin : g_bad_loss
    $error("prbs_checker: LOSS_COUNT must be 1..255");
  end

  // Tap positions as a mask over state bits (tap k lives in bit k-1).
  localparam logic [31:0] TAP_MASK32 = (NUM_BITS == 8)  ? 32'h0000_00B8 :
                                       (NUM_BITS == 16) ? 32'h0000_D008 :
                                                          32'h8020_0003;
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_MASK32[NUM_BITS-1:0];
  localparam logic [8:0] LOCK_LIM = 9'(LOCK_COUNT);
  localparam logic [8:0] LOSS_LIM = 9'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [NUM_BITS-1:0] lfsr_step(input logic [NUM_BITS-1:0] s);
    logic fb;
    fb = ~(^(s & TAP_MASK));
    return {s[NUM_BITS-2:0], fb};
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
  logic [7:0]          match_cnt_q, match_cnt_d;
  logic [7:0]          miss_cnt_q, miss_cnt_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [31:0]         word_cnt_q, word_cnt_d;
  logic [31:0]         word_err_q, word_err_d;
  logic                mismatch;
  logic                all_ones;

  assign mismatch = (i_data != lfsr_q);
  assign all_ones = &i_data;

`ifdef PRBS_BIT_ERR_COUNT_EN
  function automatic logic [31:0] popcount(input logic [NUM_BITS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  logic [31:0] bit_err_q, bit_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    word_cnt_d  = word_cnt_q;
    word_err_d  = word_err_q;
`ifdef PRBS_BIT_ERR_COUNT_EN
    bit_err_d   = bit_err_q;
`endif
    if (i_data_valid) begin
      unique case (state_q)
        ST_SEED: begin
          // All-ones is the XNOR lock-up state and can never seed a live sequence.
          if (!all_ones) begin
            lfsr_d      = lfsr_step(i_data);
            match_cnt_d = '0;
            state_d     = ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (!mismatch) begin
            lfsr_d = lfsr_step(lfsr_q);
            if (({1'b0, match_cnt_q} + 9'd1) >= LOCK_LIM) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else if (all_ones) begin
            state_d = ST_SEED;
          end else begin
            lfsr_d      = lfsr_step(i_data);
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the local generator free-runs and never reseeds while locked.
          lfsr_d     = lfsr_step(lfsr_q);
          word_cnt_d = sat_add(word_cnt_q, 32'd1);
          if (mismatch) begin
            err_d      = 1'b1;
            word_err_d = sat_add(word_err_q, 32'd1);
`ifdef PRBS_BIT_ERR_COUNT_EN
            bit_err_d  = sat_add(bit_err_q, popcount(i_data ^ lfsr_q));
`endif
            if (({1'b0, miss_cnt_q} + 9'd1) >= LOSS_LIM) begin
              locked_d   = 1'b0;
              state_d    = ST_SEED;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 8'd1;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: state_d = ST_SEED;
      endcase
    end
    if (i_clear) begin
      word_cnt_d = '0;
      word_err_d = '0;
`ifdef PRBS_BIT_ERR_COUNT_EN
      bit_err_d  = '0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_SEED;
      lfsr_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      word_err_q  <= '0;
`ifdef PRBS_BIT_ERR_COUNT_EN
      bit_err_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      word_cnt_q  <= word_cnt_d;
      word_err_q  <= word_err_d;
`ifdef PRBS_BIT_ERR_COUNT_EN
      bit_err_q   <= bit_err_d;
`endif
    end
  end

  assign o_locked         = locked_q;
  assign o_err            = err_q;
  assign o_word_count     = word_cnt_q;
  assign o_word_err_count = word_err_q;
`ifdef PRBS_BIT_ERR_COUNT_EN
  assign o_bit_err_count  = bit_err_q;
`else
  assign o_bit_err_count  = '0;
`endif

endmodule
